// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: fixed-priority arbitration with preemption among three requesters,
// sample-rate ROM address sequencing and a registered sample mux for the PWM stage.
module sfx_scheduler #(
   parameter int unsigned PERIOD   = 567,
   parameter int unsigned MIN_ADDR = 1000,
   parameter int unsigned MAX_ADDR = 40000,
   parameter int unsigned ADDR_W   = 16
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [2:0]        req_in,
   input  logic [7:0]        sel_data_in,
   input  logic [7:0]        scroll_data_in,
   input  logic [7:0]        click_data_in,
   output logic [ADDR_W-1:0] rom_addr_out,
   output logic [1:0]        effect_out,
   output logic [2:0]        pending_out,
   output logic [7:0]        sample_out,
   output logic              done_out
);

   localparam int unsigned CntW = $clog2(PERIOD);

   typedef enum logic [0:0] {StIdle, StPlay} state_e;

   state_e            state_q, state_d;
   logic [1:0]        effect_q, effect_d;
   logic [2:0]        pend_q, pend_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              done_q, done_d;
   logic [1:0]        effect_dly_q;
   logic [7:0]        sample_q;

   logic [2:0] cand;
   logic [1:0] win_eff;
   logic [2:0] win_oh;
   logic [2:0] cur_oh;
   logic [2:0] hi_mask;

   assign cand = pend_q | req_in;

   always_comb begin
      win_eff = 2'd0;
      win_oh  = 3'b000;
      if (cand[0]) begin
         win_eff = 2'd1;
         win_oh  = 3'b001;
      end else if (cand[1]) begin
         win_eff = 2'd2;
         win_oh  = 3'b010;
      end else if (cand[2]) begin
         win_eff = 2'd3;
         win_oh  = 3'b100;
      end
   end

   // hi_mask selects requesters that outrank the effect now playing
   always_comb begin
      cur_oh  = 3'b000;
      hi_mask = 3'b000;
      case (effect_q)
         2'd1:    begin cur_oh = 3'b001; hi_mask = 3'b000; end
         2'd2:    begin cur_oh = 3'b010; hi_mask = 3'b001; end
         2'd3:    begin cur_oh = 3'b100; hi_mask = 3'b011; end
         default: begin cur_oh = 3'b000; hi_mask = 3'b000; end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      effect_d = effect_q;
      pend_d   = pend_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (cand != 3'b000) begin
               state_d  = StPlay;
               effect_d = win_eff;
               addr_d   = ADDR_W'(MIN_ADDR);
               cnt_d    = '0;
               pend_d   = cand & ~win_oh;
            end
         end
         StPlay: begin
            if ((req_in & hi_mask) != 3'b000) begin
               // Preempted effect is dropped, never parked as pending
               effect_d = win_eff;
               addr_d   = ADDR_W'(MIN_ADDR);
               cnt_d    = '0;
               pend_d   = cand & ~win_oh & ~cur_oh;
            end else if ((req_in & cur_oh) != 3'b000) begin
               addr_d = ADDR_W'(MIN_ADDR);
               cnt_d  = '0;
               pend_d = pend_q | (req_in & ~cur_oh);
            end else if (cnt_q == CntW'(PERIOD - 1)) begin
               cnt_d = '0;
               if (addr_q == ADDR_W'(MAX_ADDR)) begin
                  done_d = 1'b1;
                  if (cand != 3'b000) begin
                     effect_d = win_eff;
                     addr_d   = ADDR_W'(MIN_ADDR);
                     pend_d   = cand & ~win_oh;
                  end else begin
                     state_d  = StIdle;
                     effect_d = 2'd0;
                     addr_d   = '0;
                     pend_d   = 3'b000;
                  end
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
                  pend_d = pend_q | req_in;
               end
            end else begin
               cnt_d  = cnt_q + CntW'(1);
               pend_d = pend_q | req_in;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= StIdle;
         effect_q     <= 2'd0;
         pend_q       <= 3'b000;
         addr_q       <= '0;
         cnt_q        <= '0;
         done_q       <= 1'b0;
         effect_dly_q <= 2'd0;
         sample_q     <= 8'd0;
      end else begin
         state_q      <= state_d;
         effect_q     <= effect_d;
         pend_q       <= pend_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         done_q       <= done_d;
         // Delayed effect lines up with ROM data returned one cycle after the address
         effect_dly_q <= effect_q;
         case (effect_dly_q)
            2'd1:    sample_q <= sel_data_in;
            2'd2:    sample_q <= scroll_data_in;
            2'd3:    sample_q <= click_data_in;
            default: sample_q <= 8'd0;
         endcase
      end
   end

   assign rom_addr_out = addr_q;
   assign effect_out   = effect_q;
   assign pending_out  = pend_q;
   assign sample_out   = sample_q;
   assign done_out     = done_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler with small PERIOD/address range and registered ROM models.
module tb_sfx_scheduler;

   localparam int unsigned ADDR_W = 16;

   logic              clk_in;
   logic              rst_in;
   logic [2:0]        req_in;
   logic [7:0]        sel_data;
   logic [7:0]        scroll_data;
   logic [7:0]        click_data;
   logic [ADDR_W-1:0] rom_addr;
   logic [1:0]        effect;
   logic [2:0]        pending;
   logic [7:0]        sample;
   logic              done;

   int n_total = 0;
   int n_bad   = 0;

   sfx_scheduler #(
      .PERIOD  (4),
      .MIN_ADDR(10),
      .MAX_ADDR(12),
      .ADDR_W  (ADDR_W)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .req_in        (req_in),
      .sel_data_in   (sel_data),
      .scroll_data_in(scroll_data),
      .click_data_in (click_data),
      .rom_addr_out  (rom_addr),
      .effect_out    (effect),
      .pending_out   (pending),
      .sample_out    (sample),
      .done_out      (done)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // ROMs with one-cycle read latency; contents are address low byte plus a per-ROM offset
   always @(posedge clk_in) begin
      sel_data    <= rom_addr[7:0] + 8'h10;
      scroll_data <= rom_addr[7:0] + 8'h20;
      click_data  <= rom_addr[7:0] + 8'h30;
   end

   task automatic check_val(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic pulse(input logic [2:0] r);
      req_in = r;
      step(1);
      req_in = 3'b000;
   endtask

   initial begin
      rst_in = 1'b1;
      req_in = 3'b000;
      step(2);
      rst_in = 1'b0;
      check_val("rst_effect", int'(effect), 0);
      check_val("rst_addr", int'(rom_addr), 0);
      check_val("rst_pending", int'(pending), 0);
      check_val("rst_sample", int'(sample), 0);
      check_val("rst_done", int'(done), 0);

      // Single click
      pulse(3'b100);
      check_val("click_effect", int'(effect), 3);
      check_val("click_addr0", int'(rom_addr), 10);
      step(2);
      check_val("click_sample10", int'(sample), 8'h3A);
      step(2);
      check_val("click_addr1", int'(rom_addr), 11);
      step(2);
      check_val("click_sample11", int'(sample), 8'h3B);
      step(2);
      check_val("click_addr2", int'(rom_addr), 12);
      step(3);
      check_val("click_hold12", int'(rom_addr), 12);
      check_val("click_no_early_done", int'(done), 0);
      step(1);
      check_val("click_done", int'(done), 1);
      check_val("click_idle_eff", int'(effect), 0);
      check_val("click_idle_addr", int'(rom_addr), 0);
      check_val("click_sample12", int'(sample), 8'h3C);
      step(1);
      check_val("click_done_once", int'(done), 0);
      step(1);
      check_val("click_sample_zero", int'(sample), 0);

      // Simultaneous requests
      pulse(3'b111);
      check_val("sim_effect1", int'(effect), 1);
      check_val("sim_pend", int'(pending), 3'b110);
      step(2);
      check_val("sim_sample_sel", int'(sample), 8'h1A);
      step(10);
      check_val("sim_done1", int'(done), 1);
      check_val("sim_effect2", int'(effect), 2);
      check_val("sim_addr2", int'(rom_addr), 10);
      check_val("sim_pend2", int'(pending), 3'b100);
      step(2);
      check_val("sim_sample_scroll", int'(sample), 8'h2A);
      step(10);
      check_val("sim_done2", int'(done), 1);
      check_val("sim_effect3", int'(effect), 3);
      check_val("sim_pend3", int'(pending), 0);
      step(12);
      check_val("sim_done3", int'(done), 1);
      check_val("sim_idle", int'(effect), 0);

      // Preemption of effect 3 at address 11
      step(2);
      pulse(3'b100);
      step(5);
      check_val("pre_addr11", int'(rom_addr), 11);
      pulse(3'b001);
      check_val("pre_effect", int'(effect), 1);
      check_val("pre_addr", int'(rom_addr), 10);
      check_val("pre_pend", int'(pending), 0);
      check_val("pre_no_done", int'(done), 0);
      step(3);
      check_val("pre_hold", int'(rom_addr), 10);
      step(1);
      check_val("pre_step", int'(rom_addr), 11);
      step(8);
      check_val("pre_done", int'(done), 1);
      check_val("pre_no_resume", int'(effect), 0);

      // Lower-priority duplicates collapse into one pending flag
      step(2);
      pulse(3'b001);
      pulse(3'b100);
      pulse(3'b100);
      pulse(3'b100);
      check_val("dup_pend", int'(pending), 3'b100);
      check_val("dup_effect", int'(effect), 1);
      step(9);
      check_val("dup_done1", int'(done), 1);
      check_val("dup_effect3", int'(effect), 3);
      check_val("dup_pend_clr", int'(pending), 0);
      step(12);
      check_val("dup_done3", int'(done), 1);
      check_val("dup_once", int'(effect), 0);

      // Same-effect restart colliding with completion
      step(2);
      pulse(3'b010);
      step(11);
      check_val("rs_addr12", int'(rom_addr), 12);
      pulse(3'b010);
      check_val("rs_addr", int'(rom_addr), 10);
      check_val("rs_effect", int'(effect), 2);
      check_val("rs_no_done", int'(done), 0);
      step(11);
      check_val("rs_no_done2", int'(done), 0);
      step(1);
      check_val("rs_done", int'(done), 1);
      check_val("rs_idle", int'(effect), 0);

      // Reset mid-play drops pending requests
      step(2);
      pulse(3'b111);
      check_val("mr_pend", int'(pending), 3'b110);
      step(2);
      rst_in = 1'b1;
      step(1);
      rst_in = 1'b0;
      check_val("mr_effect", int'(effect), 0);
      check_val("mr_addr", int'(rom_addr), 0);
      check_val("mr_pend0", int'(pending), 0);
      check_val("mr_sample", int'(sample), 0);
      check_val("mr_done", int'(done), 0);
      step(2);
      check_val("mr_stay_idle", int'(effect), 0);
      pulse(3'b100);
      check_val("mr_new_eff", int'(effect), 3);
      check_val("mr_new_addr", int'(rom_addr), 10);
      step(11);
      check_val("mr_no_early", int'(done), 0);
      step(1);
      check_val("mr_done3", int'(done), 1);
      check_val("mr_end_eff", int'(effect), 0);
      check_val("mr_end_pend", int'(pending), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
